// File: rtl/aural_pkg.sv
// aural_pkg: shared definitions for the aural mode controller.
//   - mode index constants (ALL = 0, SOLOk = k+1, ROTATE = NUM_CH+1)
//   - default_mask(): default per-channel enable mask for a mode index
//   - rot_state_e: ROTATE sub-state (PRIMED, STEPPING)
package aural_pkg;

  // Upper bound on channel count supported by the mask helper.
  localparam int unsigned MAX_CH   = 32;
  localparam int unsigned MODE_ALL = 0;

  typedef enum logic {
    ROT_PRIMED   = 1'b0,
    ROT_STEPPING = 1'b1
  } rot_state_e;

  function automatic int unsigned mode_solo(input int unsigned ch);
    return ch + 1;
  endfunction

  function automatic int unsigned mode_rotate(input int unsigned num_ch);
    return num_ch + 1;
  endfunction

  // SOLO modes enable a single channel; ALL and ROTATE (primed) enable all.
  function automatic logic [MAX_CH-1:0] default_mask(input int unsigned num_ch,
                                                     input int unsigned mode_idx);
    logic [MAX_CH-1:0] mask_all;
    mask_all = {MAX_CH{1'b1}} >> (MAX_CH - num_ch);
    if (mode_idx >= mode_solo(0) && mode_idx <= num_ch)
      return MAX_CH'(1) << (mode_idx - 1);
    return mask_all;
  endfunction

endpackage

// File: rtl/aural_rotator.sv
// aural_rotator: dwell counter, rotate sub-state and channel pointer.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clear        restart from PRIMED with the counter at 0 (accepted press)
//   run          high while the mode is ROTATE; counter held at 0 otherwise
//   tick         dwell advance strobe
//   dir          0 = ascending pointer, 1 = descending (sampled at expiry)
//   ch_en_rot    one-hot of the pointer value taken on this expiry
//   step         combinational expiry pulse (run & tick & count == DWELL-1)
//
// state        | meaning
// -------------+-----------------------------------------------------
// ROT_PRIMED   | ROTATE entered, all channels on, pointer not yet valid
// ROT_STEPPING | pointer valid, gate = one-hot(pointer)
module aural_rotator
  import aural_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 12,
  parameter int DWELL  = 2083
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              run,
  input  logic              tick,
  input  logic              dir,
  output logic [NUM_CH-1:0] ch_en_rot,
  output logic              step
);

  localparam int PTR_W = $clog2(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_CH - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] r_ptr;
  rot_state_e       r_state;

  logic             w_expire;
  logic [PTR_W-1:0] w_ptr_nxt;

  assign w_expire = run & tick & (r_cnt == CNT_LAST);

  // First expiry picks the starting end from dir; later ones step with wrap.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (r_state == ROT_PRIMED)
      w_ptr_nxt = dir ? PTR_LAST : '0;
    else if (!dir)
      w_ptr_nxt = (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
    else
      w_ptr_nxt = (r_ptr == '0) ? PTR_LAST : r_ptr - 1'b1;
  end

  assign ch_en_rot = NUM_CH'(1) << w_ptr_nxt;
  assign step      = w_expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_state <= ROT_PRIMED;
    end else if (clear || !run) begin
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_state <= ROT_PRIMED;
    end else if (tick) begin
      if (w_expire) begin
        r_cnt   <= '0;
        r_ptr   <= w_ptr_nxt;
        r_state <= ROT_STEPPING;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/aural_mode_ctrl.sv
// aural_mode_ctrl: button-driven channel mode controller.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   button_press   single-cycle debounced press; advances the mode
//   tick           dwell advance strobe used in ROTATE
//   dir            rotate direction (0 ascending, 1 descending)
//   mode           current mode index (0 ALL, k SOLO k-1, NUM_CH+1 ROTATE)
//   ch_en          per-channel enable mask
//   mode_change    one-cycle pulse the cycle after an accepted press
module aural_mode_ctrl
  import aural_pkg::*;
#(
  parameter  int NUM_CH = 2,
  parameter  int CNT_W  = 12,
  parameter  int DWELL  = 2083,
  localparam int MODE_W = $clog2(NUM_CH + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              button_press,
  input  logic              tick,
  input  logic              dir,
  output logic [MODE_W-1:0] mode,
  output logic [NUM_CH-1:0] ch_en,
  output logic              mode_change
);

  localparam logic [MODE_W-1:0] MODE_ROT = MODE_W'(mode_rotate(NUM_CH));
  localparam logic [MODE_W-1:0] MODE_0   = MODE_W'(MODE_ALL);

  logic [MODE_W-1:0] r_mode;
  logic [NUM_CH-1:0] r_ch_en;
  logic              r_mode_change;

  logic              w_in_rot;
  logic [MODE_W-1:0] w_mode_nxt;
  logic [MAX_CH-1:0] w_mask_full;
  logic [NUM_CH-1:0] w_ch_en_rot;
  logic              w_step;

  assign w_in_rot   = (r_mode == MODE_ROT);
  assign w_mode_nxt = w_in_rot ? MODE_0 : r_mode + 1'b1;

  always_comb begin
    w_mask_full = default_mask(NUM_CH, 32'(w_mode_nxt));
  end

  // A press always clears the rotator, so it wins over a coincident expiry.
  aural_rotator #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .DWELL  (DWELL)
  ) u_rotator (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (button_press),
    .run       (w_in_rot),
    .tick      (tick),
    .dir       (dir),
    .ch_en_rot (w_ch_en_rot),
    .step      (w_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode        <= MODE_0;
      r_ch_en       <= '1;
      r_mode_change <= 1'b0;
    end else begin
      r_mode_change <= button_press;
      if (button_press) begin
        r_mode  <= w_mode_nxt;
        r_ch_en <= w_mask_full[NUM_CH-1:0];
      end else if (w_step) begin
        r_ch_en <= w_ch_en_rot;
      end
    end
  end

  assign mode        = r_mode;
  assign ch_en       = r_ch_en;
  assign mode_change = r_mode_change;

endmodule

// File: tb/tb_aural_mode_ctrl.sv
module tb_aural_mode_ctrl;

  logic       clk;
  logic       rst_n;
  logic [2:0] press_v;
  logic       tick;
  logic       dir;

  // Instance 0: NUM_CH=2 DWELL=4; 1: NUM_CH=4 DWELL=3; 2: NUM_CH=3 DWELL=1
  logic [1:0] mode_a; logic [1:0] ch_a; logic mc_a;
  logic [2:0] mode_b; logic [3:0] ch_b; logic mc_b;
  logic [2:0] mode_c; logic [2:0] ch_c; logic mc_c;

  aural_mode_ctrl #(.NUM_CH(2), .CNT_W(12), .DWELL(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .button_press(press_v[0]), .tick(tick), .dir(dir),
    .mode(mode_a), .ch_en(ch_a), .mode_change(mc_a));
  aural_mode_ctrl #(.NUM_CH(4), .CNT_W(12), .DWELL(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .button_press(press_v[1]), .tick(tick), .dir(dir),
    .mode(mode_b), .ch_en(ch_b), .mode_change(mc_b));
  aural_mode_ctrl #(.NUM_CH(3), .CNT_W(4), .DWELL(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .button_press(press_v[2]), .tick(tick), .dir(dir),
    .mode(mode_c), .ch_en(ch_c), .mode_change(mc_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  int d_mode[3], d_ch[3], d_mc[3];
  always_comb begin
    d_mode[0] = 32'(mode_a); d_ch[0] = 32'(ch_a); d_mc[0] = 32'(mc_a);
    d_mode[1] = 32'(mode_b); d_ch[1] = 32'(ch_b); d_mc[1] = 32'(mc_b);
    d_mode[2] = 32'(mode_c); d_ch[2] = 32'(ch_c); d_mc[2] = 32'(mc_c);
  end

  // Behavioural model: mode index, dwell count and pointer (-1 = primed).
  int n_ch[3] = '{2, 4, 3};
  int dw[3]   = '{4, 3, 1};
  int m_mode[3], m_cnt[3], m_ptr[3], m_mc[3];

  function automatic int exp_ch(input int i);
    int rot;
    rot = n_ch[i] + 1;
    if (m_mode[i] == 0 || (m_mode[i] == rot && m_ptr[i] < 0))
      return (1 << n_ch[i]) - 1;
    if (m_mode[i] == rot)
      return 1 << m_ptr[i];
    return 1 << (m_mode[i] - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_mode[i] <= 0; m_cnt[i] <= 0; m_ptr[i] <= -1; m_mc[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        int rot, nm, nc, np;
        rot = n_ch[i] + 1;
        nm  = m_mode[i]; nc = m_cnt[i]; np = m_ptr[i];
        if (press_v[i]) begin
          nm = (nm == rot) ? 0 : nm + 1;
          nc = 0;
          np = -1;
        end else if (nm == rot && tick) begin
          if (nc == dw[i] - 1) begin
            nc = 0;
            if (np < 0) np = dir ? n_ch[i] - 1 : 0;
            else        np = dir ? (np + n_ch[i] - 1) % n_ch[i] : (np + 1) % n_ch[i];
          end else begin
            nc = nc + 1;
          end
        end
        m_mode[i] <= nm; m_cnt[i] <= nc; m_ptr[i] <= np; m_mc[i] <= int'(press_v[i]);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_mode[%0d]", i), d_mode[i], m_mode[i]);
        chk($sformatf("model_ch_en[%0d]", i), d_ch[i], exp_ch(i));
        chk($sformatf("model_mode_change[%0d]", i), d_mc[i], m_mc[i]);
      end
    end
  end

  initial begin
    int exp_b_ch[6]   = '{1, 2, 4, 8, 15, 15};
    int exp_b_mode[6] = '{1, 2, 3, 4, 5, 0};
    int tab_b[6]      = '{1, 2, 4, 2, 1, 8};
    int tab_c[4]      = '{1, 2, 4, 1};
    int e;

    rst_n = 1'b1; press_v = '0; tick = 1'b0; dir = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_mode_a", d_mode[0], 0);
    chk("reset_ch_a", d_ch[0], 3);
    chk("reset_mc_a", d_mc[0], 0);
    chk("reset_ch_b", d_ch[1], 15);
    cmp_en = 1'b1;
    rst_n  = 1'b1;

    // Mode cycle on NUM_CH=4, presses 3 cycles apart.
    for (int k = 0; k < 6; k++) begin
      press_v = 3'b010;
      @(negedge clk);
      press_v = '0;
      chk("cycle_ch_b", d_ch[1], exp_b_ch[k]);
      chk("cycle_mode_b", d_mode[1], exp_b_mode[k]);
      chk("cycle_mc_hi_b", d_mc[1], 1);
      @(negedge clk);
      chk("cycle_mc_lo_b", d_mc[1], 0);
      @(negedge clk);
    end

    // Back-to-back presses on NUM_CH=2 from ALL.
    press_v = 3'b001;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("b2b_mode_a", d_mode[0], k);
      chk("b2b_mc_a", d_mc[0], 1);
    end
    press_v = '0;
    @(negedge clk);
    chk("b2b_mc_end_a", d_mc[0], 0);
    chk("b2b_mode_end_a", d_mode[0], 3);

    // ROTATE with no ticks: gate stays all-on.
    repeat (100) @(negedge clk);
    chk("gate_notick_a", d_ch[0], 3);

    // Tick every cycle, DWELL=4: 11 x4, then 01, 10, ...
    tick = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      e = (j < 4) ? 3 : ((((j / 4) % 2) == 1) ? 1 : 2);
      chk("rot_seq_a", d_ch[0], e);
    end

    // Async reset while stepping with ptr=1, checked before the next edge.
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_mode_a", d_mode[0], 0);
    chk("async_rst_ch_a", d_ch[0], 3);
    chk("async_rst_mc_a", d_mc[0], 0);
    tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Press on the exact expiry cycle: press wins.
    press_v = 3'b001;
    repeat (3) @(negedge clk);
    press_v = '0;
    tick = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_expiry_ch_a", d_ch[0], 3);
    press_v = 3'b001;
    @(negedge clk);
    press_v = '0;
    tick = 1'b0;
    chk("press_expiry_mode_a", d_mode[0], 0);
    chk("press_expiry_ch_a", d_ch[0], 3);
    chk("press_expiry_mc_a", d_mc[0], 1);

    // SOLO0 with tick high: nothing moves.
    press_v = 3'b001;
    @(negedge clk);
    press_v = '0;
    tick = 1'b1;
    repeat (20) @(negedge clk);
    chk("solo_tick_mode_a", d_mode[0], 1);
    chk("solo_tick_ch_a", d_ch[0], 1);
    tick = 1'b0;

    // NUM_CH=4 rotation with a direction flip mid-way.
    press_v = 3'b010;
    repeat (5) @(negedge clk);
    press_v = '0;
    dir = 1'b0;
    tick = 1'b1;
    for (int j = 1; j <= 18; j++) begin
      @(negedge clk);
      if (j % 3 == 0) chk("rot_dir_b", d_ch[1], tab_b[j / 3 - 1]);
      if (j == 9) dir = 1'b1;
    end

    // DWELL=1: every tick in ROTATE is an expiry.
    press_v = 3'b100;
    repeat (4) @(negedge clk);
    press_v = '0;
    dir = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("dwell1_c", d_ch[2], tab_c[j]);
    end

    // Randomized traffic, checked every cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        for (int i = 0; i < 3; i++) press_v[i] = ($urandom_range(0, 39) == 0);
        tick = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 19) == 0) dir = ~dir;
        @(negedge clk);
      end
    end

    press_v = '0;
    tick = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aural_mode_ctrl.md
# aural_mode_ctrl

Parametrised multi-channel successor to the stereo aural-state controller. A single button press cycles a mode register through all-on, per-channel solo and a rotating ping-pong mode. In rotate mode a dwell counter, advanced by a sample tick, moves a one-hot channel gate in a selectable direction. It sits between the button-conditioning logic and the per-channel output gain/mute stage of the audio path.

## Interface
Parameters:
- NUM_CH, 2: number of output channels; must be ≥ 2.
- CNT_W, 12: dwell counter width.
- DWELL, 2083: ticks per rotate step; 1 ≤ DWELL < 2^CNT_W.
- MODE_W, derived as $clog2(NUM_CH+2): width of the mode index.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- button_press  in  1  single-cycle, already-debounced press pulse.
- tick  in  1  dwell advance enable (sample-rate strobe).
- dir  in  1  rotate direction: 0 = ascending channel index, 1 = descending.
- mode  out  MODE_W  current mode index (registered).
- ch_en  out  NUM_CH  per-channel enable mask (registered).
- mode_change  out  1  one-cycle pulse, asserted the cycle after a press is accepted.

## Operation
- Mode encoding:
  - 0 = ALL.
  - k = SOLO channel k-1, for k = 1..NUM_CH.
  - NUM_CH+1 = ROTATE.
- Press order: ALL → SOLO0 → … → SOLO(NUM_CH-1) → ROTATE → ALL. The sequence wraps.
- ch_en by mode:
  - ALL: all ones.
  - SOLOk: bit k only.
  - ROTATE: see the rotate sub-states below.
- ROTATE sub-states:
  - PRIMED: on entry, ch_en is all ones, the counter is 0 and the pointer is invalid.
  - On the first dwell expiry: go to STEPPING with the pointer at 0 if dir=0, or at NUM_CH-1 if dir=1. ch_en becomes the one-hot of the pointer.
  - STEPPING, on each expiry: pointer ← (ptr+1) mod NUM_CH if dir=0, else (ptr-1+NUM_CH) mod NUM_CH.
  - dir is sampled at each expiry. Changing dir mid-rotation reverses direction from the current pointer, with no skip.
- Dwell counter:
  - Increments only when tick=1 and mode=ROTATE.
  - Expiry occurs when tick=1 and count==DWELL-1; the count then wraps to 0 in the same edge.
  - Outside ROTATE the counter is held at 0.
- Arithmetic: count+1 is computed in CNT_W bits. It never exceeds DWELL-1, so no overflow path exists.

## Timing
- Reset (rst_n low, asynchronous):
  - mode=0, ch_en=all ones, mode_change=0.
  - Counter=0, rotate sub-state=PRIMED.
  - Outputs take these values immediately, not at the next clock edge.
- Reset release: the first press can be accepted on the first rising edge with rst_n high.
- Press latency: a press at edge N updates mode, ch_en and mode_change (=1) at edge N+1. mode_change falls at N+2 unless another press occurs.
- Back-to-back presses on consecutive cycles each advance the mode by one.
- Every accepted press clears the counter and resets the rotate sub-state to PRIMED.
- Press coinciding with a dwell expiry: the press wins. The mode advances out of ROTATE, the counter clears, and no pointer step occurs.
- DWELL=1: every tick in ROTATE is an expiry. The first tick leaves PRIMED, and each later tick steps the pointer.
- Rotate step latency: ch_en changes at the edge following the expiry tick.

## Structure
- Shared package aural_pkg holds:
  - the mode index constants and the function mapping a mode index to its default ch_en mask;
  - the ROTATE sub-state enum (PRIMED, STEPPING).
- Sub-module aural_rotator holds the dwell counter, sub-state and pointer.
  - Inputs: clk, rst_n, clear, run, tick, dir.
  - Outputs: ch_en_rot, step pulse.
- The top level holds the mode register, the press decode and the output mux.

## Test plan
- Reset mid-rotation: assert rst_n low while in STEPPING with ptr=1 → mode=0, ch_en=2'b11 and mode_change=0 before the next clock edge.
- Mode cycle, NUM_CH=4: six presses spaced 3 cycles apart.
  - ch_en sequence: 1111 → 0001 → 0010 → 0100 → 1000 → 1111 (ROTATE, primed) → 1111 (ALL).
  - mode_change asserts once per press.
- Rotate with DWELL=4, NUM_CH=2, dir=0, tick every cycle:
  - 11 for 4 ticks, then 01, 10, 01, each lasting 4 ticks.
  - Flip dir=1 mid-way: the next step goes to ptr-1, with no skipped channel.
- Press on the exact expiry cycle: with count=DWELL-1 and tick=1, press in ROTATE → next cycle mode=0, ch_en all ones, no pointer step visible.
- tick gating: in ROTATE with tick low for 100 cycles, ch_en stays 11 and the counter stays frozen. In SOLO0 with tick high, the counter stays 0.
- Back-to-back presses for 3 cycles from ALL, NUM_CH=2 → mode 1, 2, 3 on successive edges. mode_change is high for 3 cycles.
